regfile_wb_arbiter: RTL and testbench



---
 rtl/rv_pkg.sv | 19 +
 rtl/rr_arb2.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared widths, x0 index, writeback request struct and grant encoding
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] X0 = '0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_e;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter between ALU and load writeback
module rr_arb2
  import rv_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic req_alu,
  input  logic req_ld,
  output logic ready_alu,
  output logic ready_ld,
  output gnt_e gnt
);

  gnt_e last_grant_q, last_grant_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_grant_q <= GNT_LD;
    else          last_grant_q <= last_grant_d;
  end

  always_comb begin
    gnt          = GNT_LD;
    last_grant_d = last_grant_q;
    if (req_alu && req_ld)  gnt = (last_grant_q == GNT_LD) ? GNT_ALU : GNT_LD;
    else if (req_alu)       gnt = GNT_ALU;
    ready_alu = req_alu && (gnt == GNT_ALU);
    ready_ld  = req_ld  && (gnt == GNT_LD);
    // Only a real transfer moves the round-robin pointer.
    if (ready_alu || ready_ld) last_grant_d = gnt;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter, busy scoreboard and RAW stall; WB_BYPASS_EN adds forwarding outputs
module regfile_wb_arbiter
  import rv_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            raw_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
`ifdef WB_BYPASS_EN
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
`endif
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy_vec
);

  wb_req_t alu_req, ld_req, win;
  gnt_e    gnt;
  logic    xfer;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            pend1, pend2;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign ld_req  = '{valid: ld_valid,  rd: ld_rd,  data: ld_data};

  rr_arb2 u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_alu   (alu_valid),
    .req_ld    (ld_valid),
    .ready_alu (alu_ready),
    .ready_ld  (ld_ready),
    .gnt       (gnt)
  );

  assign win  = (gnt == GNT_ALU) ? alu_req : ld_req;
  assign xfer = alu_ready || ld_ready;

  // WAW hold: a clear landing this cycle is only visible next cycle.
  assign issue_ready = !busy_q[issue_rd] || (issue_rd == X0);

  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    if (xfer && win.valid && (win.rd != X0)) begin
      rf_we_d        = 1'b1;
      rf_rd_d        = win.rd;
      rf_wdata_d     = win.data;
      busy_d[win.rd] = 1'b0;
    end
    // Set after clear so a same-index issue keeps the register pending.
    if (issue_valid && issue_ready && (issue_rd != X0)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1_hit  = rf_we_q && (rf_rd_q == rs1) && (rs1 != X0);
  assign fwd2_hit  = rf_we_q && (rf_rd_q == rs2) && (rs2 != X0);
  assign fwd1_data = rf_wdata_q;
  assign fwd2_data = rf_wdata_q;
  assign pend1     = (rs1 != X0) && busy_q[rs1];
  assign pend2     = (rs2 != X0) && busy_q[rs2];
`else
  // The output-stage write has not reached the register file yet.
  assign pend1 = (rs1 != X0) && (busy_q[rs1] || (rf_we_q && (rf_rd_q == rs1)));
  assign pend2 = (rs2 != X0) && (busy_q[rs2] || (rf_we_q && (rf_rd_q == rs2)));
`endif

  assign raw_stall = pend1 || pend2;
  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_vec  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import rv_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            issue_valid = 1'b0;
  logic [AW-1:0]   issue_rd = '0;
  logic            issue_ready;
  logic [AW-1:0]   rs1 = '0, rs2 = '0;
  logic            raw_stall;
  logic            alu_valid = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0]   alu_rd = '0, ld_rd = '0;
  logic [XLEN-1:0] alu_data = '0, ld_data = '0;
  logic            alu_ready, ld_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy_vec;
`ifdef WB_BYPASS_EN
  logic            fwd1_hit, fwd2_hit;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
`endif

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .raw_stall(raw_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
`ifdef WB_BYPASS_EN
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  typedef struct {
    logic            alu_v;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_d;
    logic            ld_v;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_d;
    logic            iss_v;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            e_alu_rdy;
    logic            e_ld_rdy;
    logic            e_iss_rdy;
    logic            e_stall;
    logic            e_fwd1;
    logic            e_we;
    logic [AW-1:0]   e_rd;
    logic [XLEN-1:0] e_wd;
    logic [NREG-1:0] e_busy;
  } vec_t;

  vec_t vecs[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic av, input logic [AW-1:0] ard, input logic [31:0] ad,
    input logic lv, input logic [AW-1:0] lrd, input logic [31:0] ld,
    input logic iv, input logic [AW-1:0] ird, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
    input logic ear, input logic elr, input logic eir, input logic est, input logic ef1,
    input logic ewe, input logic [AW-1:0] erd, input logic [31:0] ewd, input logic [31:0] eb);
    vec_t v;
    v.alu_v = av; v.alu_rd = ard; v.alu_d = ad;
    v.ld_v = lv; v.ld_rd = lrd; v.ld_d = ld;
    v.iss_v = iv; v.iss_rd = ird; v.rs1 = r1; v.rs2 = r2;
    v.e_alu_rdy = ear; v.e_ld_rdy = elr; v.e_iss_rdy = eir; v.e_stall = est; v.e_fwd1 = ef1;
    v.e_we = ewe; v.e_rd = erd; v.e_wd = ewd; v.e_busy = eb;
    return v;
  endfunction

  task automatic idle_inputs();
    alu_valid = 0; ld_valid = 0; issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    //        alu v rd data        ld v rd data        iss v rd  rs1 rs2 | ardy lrdy irdy stall fwd1 | we rd data busy
    vecs[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,   0, 0, 1, 0, 0,   0, 0, 32'h0, 32'h0);
    vecs[1]  = mk(1, 3, 32'h33,       1, 6, 32'h66,       0, 0, 0, 0,   1, 0, 1, 0, 0,   1, 3, 32'h33, 32'h0);
    vecs[2]  = mk(1, 4, 32'h44,       1, 6, 32'h66,       0, 0, 0, 0,   0, 1, 1, 0, 0,   1, 6, 32'h66, 32'h0);
    vecs[3]  = mk(1, 4, 32'h44,       1, 7, 32'h77,       0, 0, 0, 0,   1, 0, 1, 0, 0,   1, 4, 32'h44, 32'h0);
    vecs[4]  = mk(1, 3, 32'h33,       1, 7, 32'h77,       0, 0, 0, 0,   0, 1, 1, 0, 0,   1, 7, 32'h77, 32'h0);
    vecs[5]  = mk(1, 5, 32'h1234,     0, 0, 0,            0, 0, 0, 0,   1, 0, 1, 0, 0,   1, 5, 32'h1234, 32'h0);
    vecs[6]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,   0, 0, 1, 0, 0,   0, 5, 32'h1234, 32'h0);
    vecs[7]  = mk(0, 0, 0,            1, 9, 32'h99,       0, 0, 0, 0,   0, 1, 1, 0, 0,   1, 9, 32'h99, 32'h0);
    vecs[8]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0,           1, 8, 0, 0,   1, 0, 1, 0, 0,   0, 9, 32'h99, 32'h100);
    vecs[9]  = mk(0, 0, 0,            0, 0, 0,            1, 9, 8, 0,   0, 0, 1, 1, 0,   0, 9, 32'h99, 32'h300);
    vecs[10] = mk(0, 0, 0,            0, 0, 0,            1, 9, 8, 0,   0, 0, 0, 1, 0,   0, 9, 32'h99, 32'h300);
    vecs[11] = mk(0, 0, 0,            1, 8, 32'hDEAD_BEEF, 0, 0, 8, 0,  0, 1, 1, 1, 0,   1, 8, 32'hDEAD_BEEF, 32'h200);
    vecs[12] = mk(0, 0, 0,            0, 0, 0,            0, 0, 8, 0,   0, 0, 1, !BYP, 1, 0, 8, 32'hDEAD_BEEF, 32'h200);
    vecs[13] = mk(0, 0, 0,            0, 0, 0,            0, 0, 8, 0,   0, 0, 1, 0, 0,   0, 8, 32'hDEAD_BEEF, 32'h200);
    vecs[14] = mk(1, 9, 32'h99,       0, 0, 0,            0, 0, 0, 9,   1, 0, 1, 1, 0,   1, 9, 32'h99, 32'h0);
    vecs[15] = mk(0, 0, 0,            1, 9, 32'hAB,       1, 9, 0, 0,   0, 1, 1, 0, 0,   1, 9, 32'hAB, 32'h200);

    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("reset_rf_we", {31'b0, rf_we}, 32'h0);
    check("reset_rf_rd", {27'b0, rf_rd}, 32'h0);
    check("reset_rf_wdata", rf_wdata, 32'h0);
    check("reset_busy", busy_vec, 32'h0);

    for (int i = 0; i < 16; i++) begin
      alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_d;
      ld_valid = vecs[i].ld_v; ld_rd = vecs[i].ld_rd; ld_data = vecs[i].ld_d;
      issue_valid = vecs[i].iss_v; issue_rd = vecs[i].iss_rd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      #1;
      check($sformatf("v%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].e_alu_rdy});
      check($sformatf("v%0d_ld_ready", i), {31'b0, ld_ready}, {31'b0, vecs[i].e_ld_rdy});
      check($sformatf("v%0d_issue_ready", i), {31'b0, issue_ready}, {31'b0, vecs[i].e_iss_rdy});
      check($sformatf("v%0d_raw_stall", i), {31'b0, raw_stall}, {31'b0, vecs[i].e_stall});
`ifdef WB_BYPASS_EN
      check($sformatf("v%0d_fwd1_hit", i), {31'b0, fwd1_hit}, {31'b0, vecs[i].e_fwd1});
      if (vecs[i].e_fwd1) check($sformatf("v%0d_fwd1_data", i), fwd1_data, 32'hDEAD_BEEF);
`endif
      @(posedge clock);
      #1;
      check($sformatf("v%0d_rf_we", i), {31'b0, rf_we}, {31'b0, vecs[i].e_we});
      check($sformatf("v%0d_rf_rd", i), {27'b0, rf_rd}, {27'b0, vecs[i].e_rd});
      check($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wd);
      check($sformatf("v%0d_busy", i), busy_vec, vecs[i].e_busy);
    end

    // Fill the scoreboard; x9 is already pending so its issue is refused.
    idle_inputs();
    for (int r = 1; r < NREG; r++) begin
      issue_valid = 1'b1; issue_rd = AW'(r);
      #1;
      check($sformatf("fill_issue_ready_r%0d", r), {31'b0, issue_ready}, {31'b0, (r != 9)});
      @(posedge clock);
      #1;
    end
    issue_rd = 0;
    #1;
    check("x0_issue_ready", {31'b0, issue_ready}, 32'h1);
    @(posedge clock);
    #1;
    issue_valid = 0;
    check("busy_full", busy_vec, 32'hFFFF_FFFE);
    rs1 = 0; rs2 = 0;
    #1;
    check("x0_no_stall", {31'b0, raw_stall}, 32'h0);
    rs2 = 31;
    #1;
    check("rs2_31_stall", {31'b0, raw_stall}, 32'h1);
    idle_inputs();

    // Asynchronous reset between edges with writes in flight.
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    issue_valid = 1; issue_rd = 4;
    @(posedge clock);
    #1;
    issue_rd = 8; alu_valid = 1; alu_rd = 3; alu_data = 32'h55;
    @(posedge clock);
    #1;
    idle_inputs();
    check("pre_rst_busy", busy_vec, 32'h110);
    check("pre_rst_we", {31'b0, rf_we}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_we", {31'b0, rf_we}, 32'h0);
    check("async_rst_rd", {27'b0, rf_rd}, 32'h0);
    check("async_rst_wdata", rf_wdata, 32'h0);
    check("async_rst_busy", busy_vec, 32'h0);
    check("async_rst_stall", {31'b0, raw_stall}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
